// File: rtl/tinyqv_uart_periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tinyqv_uart_periph_pkg
//  Purpose  : Shared register map, STATUS bit positions, bus size encodings
//             and the common bit-level FSM encoding of the UART peripheral.
//  Revision : 1.0  initial release
// ============================================================================
package tinyqv_uart_periph_pkg;

    // Register offsets, decoded from bus_addr[3:2]
    localparam logic [1:0] c_reg_data   = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_div    = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    // STATUS bit indices
    localparam int c_st_tx_full      = 0;
    localparam int c_st_tx_empty     = 1;
    localparam int c_st_rx_valid     = 2;
    localparam int c_st_rx_overrun   = 3;
    localparam int c_st_tx_busy      = 4;
    localparam int c_st_rx_frame_err = 5;

    // Bus access size encodings on bus_write_n / bus_read_n
    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;
    localparam logic [1:0] c_sz_idle = 2'b11;

    // Frame FSM encoding shared by the TX and RX engines
    localparam logic [1:0] c_fsm_idle  = 2'd0;
    localparam logic [1:0] c_fsm_start = 2'd1;
    localparam logic [1:0] c_fsm_data  = 2'd2;
    localparam logic [1:0] c_fsm_stop  = 2'd3;

    // Packed so that field order matches the STATUS bit indices above
    typedef struct packed {
        logic rx_frame_err;
        logic tx_busy;
        logic rx_overrun;
        logic rx_valid;
        logic tx_empty;
        logic tx_full;
    } uart_status_t;

    function automatic logic [31:0] status_word(input uart_status_t s);
        return {26'd0, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tinyqv_uart_periph_if.sv
`default_nettype none
// ============================================================================
//  Module   : tinyqv_uart_periph_if
//  Purpose  : Non-memory data bus between the CPU (master) and a peripheral.
//  Revision : 1.0  initial release
// ============================================================================
interface tinyqv_uart_periph_if;
    logic [27:0] bus_addr;
    logic [1:0]  bus_write_n;
    logic [1:0]  bus_read_n;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr, bus_write_n, bus_read_n, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_write_n, bus_read_n, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/tinyqv_uart_periph_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tinyqv_uart_periph_rx
//  Purpose  : 8N1 receiver: input synchroniser, start-bit validation,
//             mid-bit sampling; emits a one-cycle strobe per received byte.
//  Revision : 1.0  initial release
// ============================================================================
module tinyqv_uart_periph_rx
    import tinyqv_uart_periph_pkg::*;
(
    input  wire         clk,
    input  wire         rstn,
    input  wire         rxd,
    input  wire  [15:0] div,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        rx_frame_err
);

    logic        r_meta;
    logic        r_sync;
    logic        r_prev;
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_strobe;
    logic        r_ferr;
    logic [15:0] w_half;

    // (div+1)/2 without a 17-bit intermediate
    assign w_half = {1'b0, div[15:1]} + {15'd0, div[0]};

    // Synchroniser, frame FSM and sampler; reset discards any partial byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_prev   <= 1'b1;
            r_state  <= c_fsm_idle;
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_meta   <= rxd;
            r_sync   <= r_meta;
            r_prev   <= r_sync;
            r_strobe <= 1'b0;
            case (r_state)
                c_fsm_idle: begin
                    if (r_prev && !r_sync) begin
                        r_state <= c_fsm_start;
                        r_cnt   <= w_half;
                    end
                end
                c_fsm_start: begin
                    if (r_cnt == 16'd0) begin
                        // Line back high at mid start bit: treat as a glitch
                        if (r_sync) begin
                            r_state <= c_fsm_idle;
                        end else begin
                            r_state <= c_fsm_data;
                            r_cnt   <= div;
                            r_bit   <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_fsm_data: begin
                    if (r_cnt == 16'd0) begin
                        r_shift <= {r_sync, r_shift[7:1]};
                        r_cnt   <= div;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= c_fsm_stop;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    if (r_cnt == 16'd0) begin
                        r_state  <= c_fsm_idle;
                        r_strobe <= 1'b1;
                        r_ferr   <= !r_sync;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign rx_byte      = r_shift;
    assign rx_strobe    = r_strobe;
    assign rx_frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/tinyqv_uart_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tinyqv_uart_periph
//  Purpose  : UART peripheral on the non-memory data bus: 16-byte register
//             window, 8N1 TX through a small FIFO, RX holding register,
//             programmable baud divider, level interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module tinyqv_uart_periph
    import tinyqv_uart_periph_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR = 28'h8000000,
    parameter logic [15:0] DIV_RESET = 16'd103,
    parameter int          TX_DEPTH  = 4
) (
    input  wire                   clk,
    input  wire                   rstn,
    tinyqv_uart_periph_if.slave   bus,
    output logic                  uart_txd,
    input  wire                   uart_rxd,
    output logic                  uart_irq
);

    localparam int                   c_ptr_w = $clog2(TX_DEPTH);
    localparam int                   c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_depth = c_cnt_w'(TX_DEPTH);

    // Bus handshake
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        w_sel;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_reg;
    logic        w_data_rd;
    logic [31:0] w_rdata_next;

    // Registers
    logic [15:0] r_div;
    logic        r_tx_irq_en;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_overrun;
    logic        r_rx_frame_err;

    // TX FIFO
    logic [7:0]          r_fifo [TX_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_tx_count;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic                w_push;
    logic                w_pop;

    // TX engine
    logic [1:0]  r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd;
    logic        w_tx_busy;

    // RX engine
    logic [7:0]  w_rx_byte;
    logic        w_rx_strobe;
    logic        w_rx_frame_err;

    uart_status_t w_status;

    assign w_sel     = bus.bus_addr[27:4] == BASE_ADDR[27:4];
    assign w_req     = w_sel && !r_ack &&
                       (bus.bus_write_n != c_sz_idle || bus.bus_read_n != c_sz_idle);
    assign w_wr      = w_req && (bus.bus_write_n != c_sz_idle);
    assign w_rd      = w_req && (bus.bus_read_n != c_sz_idle);
    assign w_reg     = bus.bus_addr[3:2];
    assign w_data_rd = w_rd && (w_reg == c_reg_data);

    assign w_tx_full  = r_tx_count == c_depth;
    assign w_tx_empty = r_tx_count == '0;
    assign w_tx_busy  = r_tx_state != c_fsm_idle;
    assign w_pop      = (r_tx_state == c_fsm_idle) && !w_tx_empty;
    // A full FIFO still accepts a byte when the engine pops on the same edge
    assign w_push     = w_wr && (w_reg == c_reg_data) && (!w_tx_full || w_pop);

    // Read-data mux, sampled into r_rdata together with the ack
    always_comb begin
        w_status              = '0;
        w_status.tx_full      = w_tx_full;
        w_status.tx_empty     = w_tx_empty;
        w_status.rx_valid     = r_rx_valid;
        w_status.rx_overrun   = r_rx_overrun;
        w_status.tx_busy      = w_tx_busy;
        w_status.rx_frame_err = r_rx_frame_err;
        w_rdata_next          = 32'd0;
        case (w_reg)
            c_reg_data:   w_rdata_next = r_rx_valid ? {24'd0, r_rx_byte} : 32'd0;
            c_reg_status: w_rdata_next = status_word(w_status);
            c_reg_div:    w_rdata_next = {16'd0, r_div};
            default:      w_rdata_next = {31'd0, r_tx_irq_en};
        endcase
    end

    // Handshake, register writes and RX delivery
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack          <= 1'b0;
            r_rdata        <= 32'd0;
            r_div          <= DIV_RESET;
            r_tx_irq_en    <= 1'b0;
            r_rx_byte      <= 8'd0;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_rdata_next : 32'd0;
            if (w_wr) begin
                case (w_reg)
                    c_reg_status: begin
                        if (bus.bus_wdata[c_st_rx_overrun]) begin
                            r_rx_overrun <= 1'b0;
                        end
                        if (bus.bus_wdata[c_st_rx_frame_err]) begin
                            r_rx_frame_err <= 1'b0;
                        end
                    end
                    c_reg_div:  r_div       <= bus.bus_wdata[15:0];
                    c_reg_ctrl: r_tx_irq_en <= bus.bus_wdata[0];
                    default: ;
                endcase
            end
            if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end
            // Delivery wins over a same-cycle read and over a W1C clear
            if (w_rx_strobe) begin
                r_rx_byte  <= w_rx_byte;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_data_rd) begin
                    r_rx_overrun <= 1'b1;
                end
                if (w_rx_frame_err) begin
                    r_rx_frame_err <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.bus_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_tx_count <= r_tx_count + c_cnt_w'(1);
                2'b01:   r_tx_count <= r_tx_count - c_cnt_w'(1);
                default: ;
            endcase
        end
    end

    // TX frame FSM; each state lasts r_div+1 clocks, divisor reloaded per bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state <= c_fsm_idle;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                c_fsm_idle: begin
                    if (!w_tx_empty) begin
                        r_tx_shift <= r_fifo[r_rd_ptr];
                        r_tx_state <= c_fsm_start;
                        r_tx_cnt   <= r_div;
                        r_txd      <= 1'b0;
                    end
                end
                c_fsm_start: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_state <= c_fsm_data;
                        r_tx_cnt   <= r_div;
                        r_tx_bit   <= 3'd0;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                c_fsm_data: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt <= r_div;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= c_fsm_stop;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_state <= c_fsm_idle;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    tinyqv_uart_periph_rx u_rx (
        .clk          (clk),
        .rstn         (rstn),
        .rxd          (uart_rxd),
        .div          (r_div),
        .rx_byte      (w_rx_byte),
        .rx_strobe    (w_rx_strobe),
        .rx_frame_err (w_rx_frame_err)
    );

    assign bus.bus_ready = r_ack;
    assign bus.bus_rdata = r_rdata;
    assign uart_txd      = r_txd;
    assign uart_irq      = r_rx_valid | (w_tx_empty & r_tx_irq_en);

endmodule
`default_nettype wire
